// File: rtl/f_spsram_32768x128_arb_pkg.sv
// Shared constants and types for the two-requester SPSRAM arbiter.
// Optional post-reset zero sweep is enabled with `SPSRAM_ARB_INIT_EN.
package f_spsram_arb_pkg;

   localparam int ADDR_WIDTH = 15;
   localparam int DATA_WIDTH = 128;
   localparam int BE_WIDTH   = DATA_WIDTH / 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_e;

   typedef logic req_id_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   wstrb;
   } req_t;

endpackage

// File: rtl/f_spsram_32768x128_arb_if.sv
// Requester, response and SRAM-side signals of the SPSRAM arbiter.
// slave = arbiter view, master = requester/SRAM-model view.
interface f_spsram_32768x128_arb_if;
   import f_spsram_arb_pkg::*;

   logic                  req0_vld;
   logic                  req0_rdy;
   logic                  req0_wr;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic [BE_WIDTH-1:0]   req0_wstrb;
   logic                  req1_vld;
   logic                  req1_rdy;
   logic                  req1_wr;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic [BE_WIDTH-1:0]   req1_wstrb;

   logic                  rsp0_vld;
   logic [DATA_WIDTH-1:0] rsp0_data;
   logic                  rsp1_vld;
   logic [DATA_WIDTH-1:0] rsp1_data;

   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_cen;
   logic [BE_WIDTH-1:0]   sram_wen;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_q;

   modport slave (
      input  req0_vld, req0_wr, req0_addr, req0_wdata, req0_wstrb,
      input  req1_vld, req1_wr, req1_addr, req1_wdata, req1_wstrb,
      output req0_rdy, req1_rdy,
      output rsp0_vld, rsp0_data, rsp1_vld, rsp1_data,
      output sram_a, sram_cen, sram_wen, sram_d,
      input  sram_q
   );

   modport master (
      output req0_vld, req0_wr, req0_addr, req0_wdata, req0_wstrb,
      output req1_vld, req1_wr, req1_addr, req1_wdata, req1_wstrb,
      input  req0_rdy, req1_rdy,
      input  rsp0_vld, rsp0_data, rsp1_vld, rsp1_data,
      input  sram_a, sram_cen, sram_wen, sram_d,
      output sram_q
   );

endinterface

// File: rtl/f_spsram_32768x128_arb_rr.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to rr_ptr.
// The pointer itself is owned by the parent.
module f_spsram_arb_rr
   import f_spsram_arb_pkg::*;
(
   input  logic [1:0] vld,
   input  req_id_t    rr_ptr,
   output logic [1:0] gnt,
   output req_id_t    gnt_idx
);

   always_comb begin
      gnt     = 2'b00;
      gnt_idx = 1'b0;
      if (vld == 2'b11) begin
         gnt_idx = rr_ptr;
      end else begin
         gnt_idx = vld[1];
      end
      if (vld != 2'b00) begin
         gnt = (gnt_idx == 1'b1) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/f_spsram_32768x128_arb.sv
// Two-requester round-robin arbiter/sequencer in front of one 32768x128 SPSRAM.
// `SPSRAM_ARB_INIT_EN adds a zero sweep of the whole array after reset.
//
// state | meaning
// INIT  | zero sweep running, one word per cycle, requests held off
// RUN   | arbitrating requests, at most one SRAM access per cycle
module f_spsram_32768x128_arb
   import f_spsram_arb_pkg::*;
(
   input  logic                    forever_cpuclk,
   input  logic                    cpurst_b,
   f_spsram_32768x128_arb_if.slave bus,
   output logic                    init_done
);

   arb_state_e            state_q, state_d;
   req_id_t               rr_ptr_q, rr_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   req_id_t               rd_id_q, rd_id_d;
   logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
   logic [DATA_WIDTH-1:0] sram_d_q, sram_d_d;
   logic                  sram_cen_d;
   logic [BE_WIDTH-1:0]   sram_wen_d;

   logic                  run_en;
   logic [1:0]            vld;
   logic [1:0]            gnt;
   req_id_t               gnt_idx;
   req_t                  sel;
   logic                  accept;

`ifdef SPSRAM_ARB_INIT_EN
   localparam arb_state_e            STATE_RST = INIT;
   localparam logic [ADDR_WIDTH-1:0] INIT_LAST = '1;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`else
   localparam arb_state_e STATE_RST = RUN;
`endif

   // Requests are masked while reset is held so rdy never pulses during reset.
   assign run_en = cpurst_b && (state_q == RUN);
   assign vld    = {bus.req1_vld, bus.req0_vld} & {2{run_en}};

   f_spsram_arb_rr u_rr (
      .vld     (vld),
      .rr_ptr  (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign accept       = |gnt;
   assign bus.req0_rdy = gnt[0];
   assign bus.req1_rdy = gnt[1];

   always_comb begin
      if (gnt_idx == 1'b1) begin
         sel.wr    = bus.req1_wr;
         sel.addr  = bus.req1_addr;
         sel.wdata = bus.req1_wdata;
         sel.wstrb = bus.req1_wstrb;
      end else begin
         sel.wr    = bus.req0_wr;
         sel.addr  = bus.req0_addr;
         sel.wdata = bus.req0_wdata;
         sel.wstrb = bus.req0_wstrb;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rd_pend_d  = 1'b0;
      rd_id_d    = rd_id_q;
      sram_a_d   = sram_a_q;
      sram_d_d   = sram_d_q;
      sram_cen_d = 1'b1;
      sram_wen_d = '1;
`ifdef SPSRAM_ARB_INIT_EN
      init_cnt_d = init_cnt_q;
      if (cpurst_b && (state_q == INIT)) begin
         sram_cen_d = 1'b0;
         sram_wen_d = '0;
         sram_d_d   = '0;
         sram_a_d   = init_cnt_q;
         init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
         if (init_cnt_q == INIT_LAST) begin
            state_d = RUN;
         end
      end
`endif
      if (accept) begin
         sram_a_d = sel.addr;
         rr_ptr_d = ~gnt_idx;
         if (sel.wr) begin
            // An all-zero strobe is accepted but never reaches the array.
            sram_wen_d = ~sel.wstrb;
            sram_d_d   = sel.wdata;
            sram_cen_d = ~(|sel.wstrb);
         end else begin
            sram_cen_d = 1'b0;
            rd_pend_d  = 1'b1;
            rd_id_d    = gnt_idx;
         end
      end
   end

   assign bus.sram_a   = sram_a_d;
   assign bus.sram_d   = sram_d_d;
   assign bus.sram_cen = sram_cen_d;
   assign bus.sram_wen = sram_wen_d;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q   <= STATE_RST;
         rr_ptr_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= 1'b0;
         sram_a_q  <= '0;
         sram_d_q  <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
         sram_a_q  <= sram_a_d;
         sram_d_q  <= sram_d_d;
      end
   end

`ifdef SPSRAM_ARB_INIT_EN
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         init_cnt_q <= '0;
      end else begin
         init_cnt_q <= init_cnt_d;
      end
   end

   assign init_done = (state_q == RUN);
`else
   assign init_done = 1'b1;
`endif

   assign bus.rsp0_vld  = rd_pend_q && (rd_id_q == 1'b0);
   assign bus.rsp1_vld  = rd_pend_q && (rd_id_q == 1'b1);
   assign bus.rsp0_data = bus.sram_q;
   assign bus.rsp1_data = bus.sram_q;

endmodule

// File: doc/f_spsram_32768x128_arb.md
Name: f_spsram_32768x128_arb

Overview:
- Two-requester arbiter and sequencer in front of one f_spsram_32768x128 instance (15-bit address, 128-bit data, 16 active-low byte write enables, active-low CEN, read data valid on Q one cycle after access).
- Each requester has a valid/ready request channel. The block round-robins between them, issues at most one SRAM access per cycle, and returns read data on a per-requester response channel.
- After reset it optionally sweeps the array to zero before accepting traffic.

Parameters:
- ADDR_WIDTH, 15, SRAM word-address width; the array holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 128, SRAM word width in bits.
- BE_WIDTH, DATA_WIDTH/8 = 16, byte-enable width.

Ports:
- forever_cpuclk  in  1  Block and SRAM clock.
- cpurst_b  in  1  Reset, asynchronous, active-low.
- reqN_vld  in  1  Request valid, N=0,1.
- reqN_rdy  out  1  Request accepted this cycle when reqN_vld is also high.
- reqN_wr  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  Word address.
- reqN_wdata  in  DATA_WIDTH  Write data.
- reqN_wstrb  in  BE_WIDTH  Byte strobes, active-high.
- rspN_vld  out  1  Read data valid for requester N; one-cycle pulse, no backpressure.
- rspN_data  out  DATA_WIDTH  Read data.
- sram_a  out  ADDR_WIDTH  To SRAM A.
- sram_cen  out  1  To SRAM CEN, active-low.
- sram_wen  out  BE_WIDTH  To SRAM WEN, active-low per byte.
- sram_d  out  DATA_WIDTH  To SRAM D.
- sram_q  in  DATA_WIDTH  From SRAM Q.
- init_done  out  1  High once the block accepts requests.

Behaviour:
- Reset values:
  - State = INIT if SPSRAM_ARB_INIT_EN, else RUN.
  - rr_ptr = 0 (requester 0 has priority).
  - rd_pend = 0, rd_id = 0.
  - rspN_vld = 0, reqN_rdy = 0, sram_cen = 1.
  - init_done = 0 with the init feature, 1 without it.
  - init_cnt = 0.
- State machine: INIT -> RUN when init_cnt reaches 2^ADDR_WIDTH-1 and that write issues. RUN is terminal until reset.
- INIT:
  - sram_cen=0, sram_wen=all 0, sram_d=0, sram_a=init_cnt.
  - init_cnt increments each cycle; reqN_rdy=0.
  - init_done rises on the first RUN cycle, exactly 2^ADDR_WIDTH cycles after reset release.
- RUN arbitration (combinational grant):
  - Only one reqN_vld high: that requester is granted.
  - Both high: grant goes to rr_ptr.
  - reqN_rdy = grant to N. At most one rdy is high per cycle.
  - On any accept, rr_ptr <= ~granted index, so the other requester has priority next cycle.
  - A continuously valid requester waits at most one cycle.
- SRAM drive on accept (combinational from the granted request):
  - sram_a = addr.
  - Read: sram_cen=0, sram_wen=all 1.
  - Write: sram_wen = ~wstrb, sram_d = wdata.
  - Write with wstrb==0: accepted, sram_cen held 1, no SRAM access, no response.
  - No accept: sram_cen=1; sram_a and sram_d hold the last driven values.
- Read response:
  - Accepted read sets rd_pend<=1, rd_id<=N; otherwise rd_pend<=0.
  - rspN_vld = rd_pend & (rd_id==N), one cycle after accept.
  - Both rspN_data = sram_q unconditionally.
- Writes produce no response. Read-after-write to the same address in the next cycle returns the new data.
- Throughput: one access per cycle. Back-to-back reads give back-to-back rsp pulses.
- Reset asserted mid-operation: a pending response is dropped (rspN_vld forced 0 asynchronously) and the INIT sweep restarts from 0.

Optional Feature:
- Macro: SPSRAM_ARB_INIT_EN.
- Defined: INIT state, init_cnt, zero sweep and init_done behaviour as above.
- Undefined: no INIT state or counter; block enters RUN directly from reset and init_done is tied to 1. SRAM contents are undefined until written.

Decomposition:
- Shared package f_spsram_arb_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, BE_WIDTH constants.
  - State encoding: INIT=1'b0, RUN=1'b1.
  - Requester-index typedef (1 bit).
- One sub-module, f_spsram_arb_rr: a 2-way round-robin picker.
  - Inputs: vld[1:0], rr_ptr.
  - Outputs: gnt[1:0], gnt_idx.
  - Pointer update happens in the parent.

Test Plan:
- Init sweep (feature on): release reset, no requests -> init_done=0 for 32768 cycles, then 1; sram_wen=0 and sram_d=0 during the sweep; any read then returns 0.
- Write then read, requester 0: write addr 0x1234, wdata 0xA5..A5, wstrb 0xFFFF; read 0x1234 next cycle -> rsp0_vld pulses one cycle after the read accept with data 0xA5..A5; rsp1_vld stays 0.
- Byte strobes: write 0x0010 with all-ones data, wstrb 0x0001; earlier contents 0 -> read returns 0x...00FF; sram_wen=0xFFFE on the write cycle.
- Contention: req0_vld and req1_vld held high with reads for 6 cycles from reset-RUN -> grants 0,1,0,1,0,1; rsp ids alternate one cycle later.
- wstrb==0 write: req1 write with wstrb 0 -> req1_rdy=1, sram_cen stays 1, no rsp pulse, rr_ptr flips to 0.
- Reset mid-read: accept a read, assert cpurst_b low before the next edge -> rsp0_vld is 0, and after release init restarts from address 0.
